// File: rtl/regfile_mp_if.sv
// Port bundle between the core (master) and the multi-port register file (slave).
// Flattened buses: port k of a field sits at bits [k*W +: W].
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
);
  logic                init_done;
  logic [1:0]          we;
  logic [2*AW-1:0]     waddr;
  logic [2*XLEN-1:0]   wdata;
  logic [1:0]          wclr;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;

  modport master (
    input  init_done, rdata, rbusy,
    output we, waddr, wdata, wclr, re, raddr, iss_en, iss_addr
  );

  modport slave (
    input  we, waddr, wdata, wclr, re, raddr, iss_en, iss_addr,
    output init_done, rdata, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with issue busy scoreboard and post-reset clear sweep.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus,
  output logic         state_dbg_o
);
  // Handshake: none; writes and issues take effect on the clock edge they are
  // presented, reads are combinational, all qualified by init_done.
  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [AW-1:0]     waddr_w [2];
  logic [XLEN-1:0]   wdata_w [2];
  logic              run_w;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      waddr_w[k] = bus.waddr[k*AW +: AW];
      wdata_w[k] = bus.wdata[k*XLEN +: XLEN];
    end
  end

  assign run_w         = (state_q == S_RUN) && !rst;
  assign bus.init_done = run_w;
  assign state_dbg_o   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter MSB marks the sweep end, so it never wraps back to r0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + (AW+1)'(1);
        if (cnt_d[AW]) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Later loop iterations win, giving write port 1 priority on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        regs_q[cnt_q[AW-1:0]] <= '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (bus.we[k] && (waddr_w[k] != '0)) regs_q[waddr_w[k]] <= wdata_w[k];
        end
      end
    end
  end

  // Issue is applied after write-back clears: the newer producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (state_q == S_INIT) begin
      busy_d[cnt_q[AW-1:0]] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (bus.we[k] && bus.wclr[k]) busy_d[waddr_w[k]] = 1'b0;
      end
      if (bus.iss_en && (bus.iss_addr != '0)) busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= busy_d;
  end

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] val;
      ra  = bus.raddr[p*AW +: AW];
      val = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < 2; k++) begin
        if (bus.we[k] && (waddr_w[k] != '0) && (waddr_w[k] == ra)) val = wdata_w[k];
      end
`endif
      bus.rdata[p*XLEN +: XLEN] = (run_w && bus.re[p] && (ra != '0)) ? val : '0;
      bus.rbusy[p]              = run_w && (ra != '0) && busy_q[ra];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sweep, writes, reads, bypass and scoreboard.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic clk;
  logic rst;
  logic state_dbg;
  int   n_vec;
  int   n_err;
  logic [XLEN-1:0] exp_q[$];

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.we     = '0;
    bus.wclr   = '0;
    bus.iss_en = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic clr);
    bus.we[k]                  = 1'b1;
    bus.waddr[k*AW +: AW]      = a;
    bus.wdata[k*XLEN +: XLEN]  = d;
    bus.wclr[k]                = clr;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic en);
    bus.raddr[p*AW +: AW] = a;
    bus.re[p]             = en;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus.iss_en   = 1'b1;
    bus.iss_addr = a;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!bus.init_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [XLEN-1:0] rdata_p(input int p);
    return bus.rdata[p*XLEN +: XLEN];
  endfunction

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.we = '0; bus.waddr = '0; bus.wdata = '0; bus.wclr = '0;
    bus.re = '0; bus.raddr = '0; bus.iss_en = 1'b0; bus.iss_addr = '0;

    // reset and first sweep
    tick(); tick();
    rd(0, 5'd5, 1'b1);
    settle();
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_rdata", rdata_p(0), 32'd0);
    rst = 1'b0;
    wait_init(n);
    chk("sweep_len", n, NREG);
    chk("state_run", 32'(state_dbg), 32'd1);
    for (int a = 0; a < NREG; a++) begin
      rd(0, AW'(a), 1'b1);
      settle();
      chk("sweep_zero", rdata_p(0), 32'd0);
      chk("sweep_busy", 32'(bus.rbusy[0]), 32'd0);
    end

    // mid-sweep reset restarts the count; writes/issues in INIT ignored
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    while (!bus.init_done && n < 200) begin
      idle();
      if (n >= 20 && n < 23) begin
        wr(0, 5'd4, 32'h1111_1111, 1'b0);
        wr(1, 5'd4, 32'h2222_2222, 1'b0);
        issue(5'd4);
      end
      settle();
      if (n == 21) chk("init_rdata_gate", rdata_p(0), 32'd0);
      tick();
      n++;
    end
    idle();
    chk("resweep_len", n, NREG);
    rd(0, 5'd4, 1'b1);
    settle();
    chk("init_ignore_wr", rdata_p(0), 32'd0);
    chk("init_ignore_iss", 32'(bus.rbusy[0]), 32'd0);

    // basic write / read, r0 and re=0
    exp_q.push_back(32'hDEAD_BEEF);
    wr(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    tick(); idle();
    rd(0, 5'd5, 1'b1);
    settle();
    chk("basic_wr", rdata_p(0), exp_q.pop_front());
    rd(0, 5'd5, 1'b0);
    settle();
    chk("re_off", rdata_p(0), 32'd0);
    wr(0, 5'd0, 32'h0000_1234, 1'b0);
    tick(); idle();
    rd(0, 5'd0, 1'b1);
    settle();
    chk("r0_zero", rdata_p(0), 32'd0);

    // dual write collision: port 1 wins
    wr(0, 5'd7, 32'hAAAA_0000, 1'b0);
    wr(1, 5'd7, 32'h5555_FFFF, 1'b0);
    tick(); idle();
    rd(0, 5'd7, 1'b1);
    settle();
    chk("dual_wr_p1", rdata_p(0), 32'h5555_FFFF);

    // same-cycle read of a write
    wr(0, 5'd9, 32'h0BAD_F00D, 1'b0);
    rd(1, 5'd9, 1'b1);
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same", rdata_p(1), 32'h0BAD_F00D);
`else
    chk("bypass_same", rdata_p(1), 32'd0);
`endif
    tick(); idle();
    settle();
    chk("bypass_next", rdata_p(1), 32'h0BAD_F00D);

    // scoreboard
    rd(0, 5'd3, 1'b1);
    issue(5'd3);
    settle();
    chk("busy_not_fwd", 32'(bus.rbusy[0]), 32'd0);
    tick(); idle();
    settle();
    chk("busy_set", 32'(bus.rbusy[0]), 32'd1);
    wr(0, 5'd3, 32'h0000_0042, 1'b1);
    settle();
    chk("busy_clr_pending", 32'(bus.rbusy[0]), 32'd1);
    tick(); idle();
    settle();
    chk("busy_clr", 32'(bus.rbusy[0]), 32'd0);
    chk("wb_data", rdata_p(0), 32'h0000_0042);
    issue(5'd3);
    wr(0, 5'd3, 32'h0000_0043, 1'b1);
    tick(); idle();
    rd(0, 5'd3, 1'b0);
    settle();
    chk("set_wins", 32'(bus.rbusy[0]), 32'd1);
    chk("re_off_data", rdata_p(0), 32'd0);
    wr(1, 5'd3, 32'h0000_0044, 1'b1);
    tick(); idle();
    settle();
    chk("busy_clr_p1", 32'(bus.rbusy[0]), 32'd0);
    issue(5'd6);
    tick(); idle();
    wr(0, 5'd6, 32'h0000_0066, 1'b0);
    tick(); idle();
    rd(1, 5'd6, 1'b1);
    settle();
    chk("no_wclr_keep", 32'(bus.rbusy[1]), 32'd1);
    issue(5'd0);
    tick(); idle();
    rd(0, 5'd0, 1'b1);
    settle();
    chk("issue_r0", 32'(bus.rbusy[0]), 32'd0);

    // reset gates outputs, then sweep clears state
    rd(0, 5'd5, 1'b1);
    rst = 1'b1;
    settle();
    chk("rst_gate_data", rdata_p(0), 32'd0);
    chk("rst_gate_busy", 32'(bus.rbusy[1]), 32'd0);
    chk("rst_gate_done", 32'(bus.init_done), 32'd0);
    tick(); rst = 1'b0;
    settle();
    chk("init_gate_data", rdata_p(0), 32'd0);
    wait_init(n);
    chk("final_sweep_len", n, NREG);
    settle();
    chk("final_r5", rdata_p(0), 32'd0);
    chk("final_r6_busy", 32'(bus.rbusy[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation core. It has NRD read ports and two write-back ports, and a per-register busy scoreboard for issue-time hazard detection. After reset it runs a sequential clear sweep, so every register reads zero before the core starts. It sits between decode/issue (reads, busy set) and write-back (writes, busy clear).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; power of two, at least 4
AW, log2(NREG), register address width
NRD, 2, number of read ports, 1..4

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
init_done  out  1  high once the clear sweep has finished
we  in  2  per-write-port enable; bit k belongs to port k
waddr  in  2*AW  write addresses, port k at bits [k*AW +: AW]
wdata  in  2*XLEN  write data, port k at bits [k*XLEN +: XLEN]
wclr  in  2  per-write-port "clear busy" flag, qualified by we[k]
re  in  NRD  read enables
raddr  in  NRD*AW  read addresses, flattened the same way as waddr
rdata  out  NRD*XLEN  read data, flattened
rbusy  out  NRD  busy bit of each read address
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  AW  destination register being issued

Behaviour:
- Reset and clock: reset rst, synchronous, active-high; clock clk.
- FSM states:
  - INIT: entered on rst, from any state and mid-sweep included. Sweep counter restarts at 0. One register is zeroed and its busy bit cleared per cycle. After index NREG-1 is written, the next cycle moves to RUN.
  - RUN: normal operation. Only rst leaves it.
- Reset and INIT output values:
  - init_done=0 while rst is high and throughout INIT.
  - init_done=1 from the first RUN cycle.
  - rdata=0 and rbusy=0 on all ports while rst is high or in INIT.
  - we and iss_en are ignored in INIT. NREG cycles pass from rst deassertion to init_done.
- Writes (RUN): on the clock edge, regs[waddr[k]] <= wdata[k] when we[k]=1 and waddr[k]!=0.
  - Both ports writing the same address: port 1 wins.
  - Writes to r0 are discarded.
- Reads (RUN): combinational, zero latency.
  - raddr=0 gives rdata=0 and rbusy=0.
  - re=0 gives rdata=0. rbusy still reflects the scoreboard.
  - With re=1, rdata=regs[raddr], subject to bypass (see Optional Feature).
- Scoreboard (RUN): one busy bit per register; bit 0 is hard-wired to 0.
  - Set on the edge when iss_en=1 and iss_addr!=0.
  - Cleared on the edge when we[k]=1, wclr[k]=1 and waddr[k] equals the register index.
  - Set and clear of the same register in the same cycle: set wins, because the newer producer owns it.
  - rbusy is registered state, not forwarded. A clear becomes visible the cycle after write-back.
- Arithmetic: the sweep counter is AW+1 bits wide, so reaching NREG terminates without wrap.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read that matches an enabled, non-zero write address in the same cycle returns the write data. Port 1 takes priority over port 0. This is same-cycle write-to-read forwarding.
- Undefined: reads always return the stored array value, so a same-cycle write shows up on the next cycle.
- Scoreboard timing is identical in both builds.

Test Plan:
- Sweep after reset: rst for 2 cycles, then release -> init_done=0 for exactly NREG=32 cycles, then 1; every raddr reads 0, rbusy=0. Pulse rst again mid-sweep (cycle 10) -> the 32-cycle count restarts.
- Basic write/read: we=01, waddr0=5, wdata0=0xDEADBEEF -> next cycle raddr[0]=5 gives 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Dual write, same address: port 0 writes 0xAAAA_0000 and port 1 writes 0x5555_FFFF to r7 in one cycle -> r7 reads 0x5555_FFFF.
- Bypass: write 0x0BAD_F00D to r9 while raddr[1]=9 -> same-cycle rdata[1]=0x0BAD_F00D when REGFILE_BYPASS_EN is defined; the old value (0) when it is not.
- Scoreboard: issue r3 -> rbusy=1 next cycle. Write back r3 with wclr=1 -> rbusy=0 the following cycle. Issue and clear r3 in the same cycle -> rbusy stays 1. Issue r0 -> rbusy stays 0.
- Ignored in INIT: we=11 and iss_en=1 to r4 during the sweep -> after init_done, r4 reads 0 and is not busy.
